sim_pci_irq_arbiter: RTL

SIM_PCI_IRQ_ARBITER -- requirements
Module: sim_pci_irq_arbiter

---
 rtl/sim_pci_irq_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sim_pci_irq_arbiter.sv
// sim_pci_irq_arbiter: round-robin interrupt arbiter that answers each granted
// level request with a delayed one-cycle acknowledge pulse on that channel.
// Optional feature macro SIM_PCI_DOUBLE_ACK_EN: issue a second acknowledge
// pulse ACK_GAP edges after the first (adds the GAP state and its counter load).
module sim_pci_irq_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int ACK_DELAY = 5,
    parameter int ACK_GAP   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] irq_req,
    output logic [NUM_CH-1:0] irq_ack,
    output logic              busy,
    output logic [3:0]        active_ch,
    output logic [31:0]       ack_count
);

`ifdef SIM_PCI_DOUBLE_ACK_EN
    typedef enum logic [1:0] {IDLE, DELAY, GAP} state_t;
    // The GAP count fires when it reaches zero, so it is preloaded one short.
    localparam logic [15:0] GAP_LOAD = 16'(ACK_GAP - 1);
`else
    typedef enum logic [0:0] {IDLE, DELAY} state_t;
`endif

    // DELAY fires on the edge after the count reaches zero, giving ACK_DELAY+1
    // edges from grant to the visible pulse.
    localparam logic [15:0]       DELAY_LOAD = 16'(ACK_DELAY);
    localparam logic [NUM_CH-1:0] ACK_ONE    = NUM_CH'(1);

    state_t            state, state_n;
    logic [15:0]       cnt, cnt_n;
    logic [3:0]        rr_ptr, rr_n;
    logic [NUM_CH-1:0] ack_n;
    logic              busy_n;
    logic [3:0]        active_n;
    logic              ack_inc;
    logic              found;
    logic [3:0]        pick_idx;

    // Returns {found, index} of the first requester at or above ptr, wrapping.
    function automatic logic [4:0] rr_pick(input logic [NUM_CH-1:0] req,
                                           input logic [3:0] ptr);
        logic              hit;
        logic [3:0]        idx;
        logic [NUM_CH-1:0] sh;
        int                c;
        hit = 1'b0;
        idx = 4'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = int'(ptr) + i;
            if (c >= NUM_CH) c = c - NUM_CH;
            sh = req >> c;
            if (!hit && sh[0]) begin
                hit = 1'b1;
                idx = 4'(c);
            end
        end
        return {hit, idx};
    endfunction

    // Next-state, counter, pointer and output decode for the arbiter FSM.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rr_n     = rr_ptr;
        ack_n    = '0;
        busy_n   = busy;
        active_n = active_ch;
        ack_inc  = 1'b0;
        {found, pick_idx} = rr_pick(irq_req, rr_ptr);
        case (state)
            IDLE: begin
                // busy stays up through the final pulse cycle, then drops here
                busy_n = 1'b0;
                if (found) begin
                    state_n  = DELAY;
                    cnt_n    = DELAY_LOAD;
                    active_n = pick_idx;
                    busy_n   = 1'b1;
                    if (int'(pick_idx) == NUM_CH - 1) rr_n = 4'd0;
                    else                              rr_n = pick_idx + 4'd1;
                end
            end
            DELAY: begin
                if (cnt != 16'd0) begin
                    cnt_n = cnt - 16'd1;
                end else begin
                    ack_n   = ACK_ONE << active_ch;
                    ack_inc = 1'b1;
`ifdef SIM_PCI_DOUBLE_ACK_EN
                    state_n = GAP;
                    cnt_n   = GAP_LOAD;
`else
                    state_n = IDLE;
`endif
                end
            end
`ifdef SIM_PCI_DOUBLE_ACK_EN
            GAP: begin
                if (cnt != 16'd0) begin
                    cnt_n = cnt - 16'd1;
                end else begin
                    ack_n   = ACK_ONE << active_ch;
                    ack_inc = 1'b1;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // State, counter and registered outputs; reset cancels any grant in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            rr_ptr    <= 4'd0;
            irq_ack   <= '0;
            busy      <= 1'b0;
            active_ch <= 4'd0;
            ack_count <= 32'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rr_ptr    <= rr_n;
            irq_ack   <= ack_n;
            busy      <= busy_n;
            active_ch <= active_n;
            if (ack_inc) ack_count <= ack_count + 32'd1;
        end
    end

endmodule
